// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin arbiter sharing one I/O command channel among num_req_p masters, with an
// in-order tag FIFO routing untagged responses back to the oldest requester. Optional: BP_IO_ARB_ERR_EN.
module bp_io_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int max_outstanding_p = 4,
  parameter int msg_width_p       = 128
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] io_cmd_i,
  input  logic [num_req_p-1:0]             io_cmd_v_i,
  output logic [num_req_p-1:0]             io_cmd_yumi_o,
  output logic [msg_width_p-1:0]           io_resp_o,
  output logic [num_req_p-1:0]             io_resp_v_o,
  input  logic [num_req_p-1:0]             io_resp_ready_i,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
`ifdef BP_IO_ARB_ERR_EN
  output logic                             err_o,
`endif
  output logic                             io_resp_yumi_o
);

  localparam int req_w = $clog2(num_req_p);
  localparam int cnt_w = $clog2(max_outstanding_p + 1);
  localparam int ptr_w = $clog2(max_outstanding_p);

  // Handshakes: a producer raises valid independently of the consumer's yumi/ready;
  // a transfer happens in any cycle where valid and yumi (or valid and ready) are both 1.

  logic [req_w-1:0] rr_ptr;
  logic [req_w-1:0] grant;
  logic             grant_found;
  logic [cnt_w-1:0] count;
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [req_w-1:0] tag_q [max_outstanding_p];
  logic [req_w-1:0] head;
  logic             active;
  logic             full;
  logic             empty;
  logic             issue;
  logic             retire;

  assign active = ~reset_i;
  assign full   = (count == cnt_w'(max_outstanding_p));
  assign empty  = (count == '0);
  assign head   = tag_q[rd_ptr];

  // Search upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    int               cand_int;
    logic [req_w-1:0] cand;
    cand_int    = 0;
    cand        = '0;
    grant       = rr_ptr;
    grant_found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      cand_int = int'(rr_ptr) + i;
      if (cand_int >= num_req_p) cand_int = cand_int - num_req_p;
      cand = req_w'(cand_int);
      if (!grant_found && io_cmd_v_i[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  // Full uses the registered count, so a same-cycle retire never opens a slot early.
  assign io_cmd_v_o = active & grant_found & ~full;
  assign io_cmd_o   = io_cmd_i[grant*msg_width_p +: msg_width_p];
  assign issue      = io_cmd_v_o & io_cmd_yumi_i;

  always_comb begin
    io_cmd_yumi_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      io_cmd_yumi_o[i] = issue && (int'(grant) == i);
    end
  end

  assign io_resp_o = io_resp_i;
  assign retire    = active & io_resp_v_i & ~empty & io_resp_ready_i[head];

  always_comb begin
    io_resp_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      io_resp_v_o[i] = active && io_resp_v_i && !empty && (int'(head) == i);
    end
  end

`ifdef BP_IO_ARB_ERR_EN
  // A response with nothing outstanding is swallowed so the converter can't stall forever.
  logic stray;
  logic err_q;

  assign stray          = active & io_resp_v_i & empty;
  assign io_resp_yumi_o = retire | stray;
  assign err_o          = err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (stray) begin
      err_q <= 1'b1;
    end
  end
`else
  assign io_resp_yumi_o = retire;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (int'(grant) == num_req_p - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else begin
      case ({issue, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (issue)  wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Tag storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (issue) tag_q[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Table-driven bench for bp_io_cmd_arbiter; a response-routing scoreboard queue is filled at issue
// and drained at retire. Build with BP_IO_ARB_ERR_EN to exercise the err_o variant.
module tb_bp_io_cmd_arbiter;

  localparam int NR = 2;
  localparam int MO = 4;
  localparam int MW = 128;
`ifdef BP_IO_ARB_ERR_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic [NR*MW-1:0]  io_cmd_i;
  logic [NR-1:0]     io_cmd_v_i;
  logic [NR-1:0]     io_cmd_yumi_o;
  logic [MW-1:0]     io_resp_o;
  logic [NR-1:0]     io_resp_v_o;
  logic [NR-1:0]     io_resp_ready_i;
  logic [MW-1:0]     io_cmd_o;
  logic              io_cmd_v_o;
  logic              io_cmd_yumi_i;
  logic [MW-1:0]     io_resp_i;
  logic              io_resp_v_i;
  logic              io_resp_yumi_o;
`ifdef BP_IO_ARB_ERR_EN
  logic              err_o;
`endif

  bp_io_cmd_arbiter #(.num_req_p(NR), .max_outstanding_p(MO), .msg_width_p(MW)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .io_cmd_i       (io_cmd_i),
    .io_cmd_v_i     (io_cmd_v_i),
    .io_cmd_yumi_o  (io_cmd_yumi_o),
    .io_resp_o      (io_resp_o),
    .io_resp_v_o    (io_resp_v_o),
    .io_resp_ready_i(io_resp_ready_i),
    .io_cmd_o       (io_cmd_o),
    .io_cmd_v_o     (io_cmd_v_o),
    .io_cmd_yumi_i  (io_cmd_yumi_i),
    .io_resp_i      (io_resp_i),
    .io_resp_v_i    (io_resp_v_i),
`ifdef BP_IO_ARB_ERR_EN
    .err_o          (err_o),
`endif
    .io_resp_yumi_o (io_resp_yumi_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd_v;
    logic       yumi;
    logic       resp_v;
    logic [1:0] ready;
    logic       exp_cmd_v;
    int         exp_grant;
    logic [1:0] exp_cmd_yumi;
    logic [1:0] exp_resp_v;
    logic       exp_resp_yumi;
    logic       exp_err;
  } vec_t;

  vec_t          vecs[$];
  logic [1:0]    exp_q[$];
  logic [MW-1:0] cmd_slot [NR];
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic void chk(string name, logic [MW-1:0] act, logic [MW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void add(logic [1:0] cmd_v, logic yumi, logic resp_v, logic [1:0] ready,
                              logic exp_cmd_v, int exp_grant, logic [1:0] exp_cmd_yumi,
                              logic [1:0] exp_resp_v, logic exp_resp_yumi, logic exp_err);
    vec_t v;
    v.cmd_v = cmd_v; v.yumi = yumi; v.resp_v = resp_v; v.ready = ready;
    v.exp_cmd_v = exp_cmd_v; v.exp_grant = exp_grant; v.exp_cmd_yumi = exp_cmd_yumi;
    v.exp_resp_v = exp_resp_v; v.exp_resp_yumi = exp_resp_yumi; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // driver: one table row per clock, outputs sampled 2ns after the falling edge
  task automatic apply(input vec_t v, input int n);
    logic [MW-1:0] rd;
    logic [1:0]    sb;
    @(negedge clk);
    io_cmd_v_i      = v.cmd_v;
    io_cmd_yumi_i   = v.yumi;
    io_resp_v_i     = v.resp_v;
    io_resp_ready_i = v.ready;
    rd = {$urandom, $urandom, $urandom, $urandom};
    io_resp_i = rd;
    if (v.yumi && v.exp_cmd_v) exp_q.push_back(v.exp_cmd_yumi);
    #2;
    chk($sformatf("row%0d cmd_v_o", n), io_cmd_v_o, v.exp_cmd_v);
    chk($sformatf("row%0d cmd_yumi_o", n), io_cmd_yumi_o, v.exp_cmd_yumi);
    chk($sformatf("row%0d resp_v_o", n), io_resp_v_o, v.exp_resp_v);
    chk($sformatf("row%0d resp_yumi_o", n), io_resp_yumi_o, v.exp_resp_yumi);
    chk($sformatf("row%0d resp_data", n), io_resp_o, rd);
    if (v.exp_cmd_v) chk($sformatf("row%0d cmd_data", n), io_cmd_o, cmd_slot[v.exp_grant]);
    if (v.exp_resp_yumi && v.exp_resp_v != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL row%0d sb_underflow: got retire expected none", n);
      end else begin
        sb = exp_q.pop_front();
        chk($sformatf("row%0d sb_route", n), io_resp_v_o, sb);
      end
    end
`ifdef BP_IO_ARB_ERR_EN
    chk($sformatf("row%0d err_o", n), err_o, v.exp_err);
`endif
  endtask

  int split;

  initial begin
    cmd_slot[0] = {$urandom, $urandom, $urandom, $urandom};
    cmd_slot[1] = {$urandom, $urandom, $urandom, $urandom};
    io_cmd_i        = {cmd_slot[1], cmd_slot[0]};
    io_cmd_v_i      = 2'b11;
    io_cmd_yumi_i   = 1'b1;
    io_resp_v_i     = 1'b1;
    io_resp_ready_i = 2'b11;
    io_resp_i       = '0;

    //  cmd_v  y  rv  rdy    v  g  cy     rv     ry  err
    add(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);   // idle after reset
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);   // fill: 0,1,0,1
    add(2'b11, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
    add(2'b11, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
    add(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);   // full
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 0);   // responses A..D
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 0);
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 0);
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);   // issue resumes
    add(2'b10, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);   // only req 1, no bubbles
    add(2'b10, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
    add(2'b10, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
    add(2'b11, 0, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 0);   // full + retire: no issue
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);   // issue next cycle, rr was 0
    add(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);   // full again
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 0);
    add(2'b11, 1, 1, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0);   // issue + retire together
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
    add(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);   // count held across issue+retire
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 1, 2'b10, 0, 0, 2'b00, 2'b01, 0, 0);   // head 0 not ready x3
    add(2'b00, 0, 1, 2'b10, 0, 0, 2'b00, 2'b01, 0, 0);
    add(2'b00, 0, 1, 2'b10, 0, 0, 2'b00, 2'b01, 0, 0);
    add(2'b00, 0, 1, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);   // ready rises: one pop
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 0);   // now empty
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b00, E, 0);   // stray response
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b00, E, E);
    add(2'b11, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, E);   // rr=1 from earlier grant 0
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, E);
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, E);   // two outstanding, rr ends at 1
    add(2'b01, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, E);
    split = vecs.size();
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b00, E, 0);   // after reset: tags discarded
    add(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, E);   // rr back at 0
    add(2'b00, 0, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, E);

    #12;
    chk("in_reset cmd_v_o", io_cmd_v_o, 1'b0);
    chk("in_reset cmd_yumi_o", io_cmd_yumi_o, 2'b00);
    chk("in_reset resp_v_o", io_resp_v_o, 2'b00);
    chk("in_reset resp_yumi_o", io_resp_yumi_o, 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
    io_cmd_v_i = '0; io_cmd_yumi_i = 1'b0; io_resp_v_i = 1'b0; io_resp_ready_i = '0;

    for (int i = 0; i < split; i++) apply(vecs[i], i);

    // asynchronous reset with two commands outstanding, asserted mid-cycle
    @(negedge clk);
    io_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1; io_resp_v_i = 1'b1; io_resp_ready_i = 2'b00;
    #1;
    chk("pre_reset resp_v_o", io_resp_v_o, 2'b01);
    #1 reset_i = 1'b1;
    #1;
    chk("async_reset cmd_v_o", io_cmd_v_o, 1'b0);
    chk("async_reset cmd_yumi_o", io_cmd_yumi_o, 2'b00);
    chk("async_reset resp_v_o", io_resp_v_o, 2'b00);
    chk("async_reset resp_yumi_o", io_resp_yumi_o, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_i = 1'b0;
    io_cmd_v_i = '0; io_cmd_yumi_i = 1'b0; io_resp_v_i = 1'b0; io_resp_ready_i = '0;
`ifdef BP_IO_ARB_ERR_EN
    #1 chk("post_reset err_o", err_o, 1'b0);
`endif

    for (int i = split; i < vecs.size(); i++) apply(vecs[i], i);

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_io_cmd_arbiter.md
Name: bp_io_cmd_arbiter

Overview:
- Shares one I/O command channel (the I/O-command to LCE-request converter) between num_req_p I/O masters.
- Round-robin arbitration on commands.
- In-order tag FIFO of requester indices; I/O responses carry no source id, so each response is routed back to the oldest outstanding requester.
- Sits between the I/O masters (for example the config/debug link and the DMA) and the converter in the I/O complex.

Parameters:
- num_req_p, 2, number of requesters; must be ≥2.
- max_outstanding_p, 4, max commands in flight; also the tag FIFO depth; power of 2, ≥2.
- msg_width_p, 128, width of one packed bedrock memory message.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- io_cmd_i  in  num_req_p*msg_width_p  requester commands; slot i = bits [i*msg_width_p +: msg_width_p]
- io_cmd_v_i  in  num_req_p  per-requester command valid
- io_cmd_yumi_o  out  num_req_p  per-requester command consumed
- io_resp_o  out  msg_width_p  response data, broadcast to all requesters
- io_resp_v_o  out  num_req_p  response valid, one-hot to the target requester
- io_resp_ready_i  in  num_req_p  per-requester response ready
- io_cmd_o  out  msg_width_p  arbitrated command to the converter
- io_cmd_v_o  out  1  arbitrated command valid
- io_cmd_yumi_i  in  1  converter consumed the command
- io_resp_i  in  msg_width_p  response from the converter
- io_resp_v_i  in  1  response valid
- io_resp_yumi_o  out  1  response consumed

Behaviour:
- Reset (asynchronous, active-high):
  - rr_ptr=0, outstanding count=0, tag FIFO empty.
  - All yumi and valid outputs are 0 while reset_i is high.
  - Reset mid-transaction discards all in-flight tags. Responses returned after reset are not routed.
- Arbitration:
  - Combinational grant = first requester with io_cmd_v_i set, searching upward from rr_ptr with wrap-around (num_req_p-1 → 0).
- Command issue:
  - io_cmd_v_o = any io_cmd_v_i & ~full, where full = (count == max_outstanding_p).
  - io_cmd_o = command of the granted requester; it is a don't-care when io_cmd_v_o=0.
  - io_cmd_v_o never depends on io_cmd_yumi_i.
  - Grant is held stable while io_cmd_v_o=1 and no yumi has arrived, as long as the requester inputs do not change.
- On io_cmd_yumi_i (legal only when io_cmd_v_o=1):
  - io_cmd_yumi_o[grant]=1 in the same cycle, all other bits 0.
  - Grant index is pushed into the tag FIFO.
  - rr_ptr <= grant+1 mod num_req_p.
  - Count increments unless a retire happens in the same cycle.
- Full:
  - Full is computed from the registered count, so no issue occurs while full, even if a response retires in that same cycle.
  - Issue resumes the next cycle.
- Response routing:
  - head = tag FIFO head.
  - io_resp_v_o = onehot(head) when io_resp_v_i & ~empty; otherwise 0.
  - io_resp_o = io_resp_i (pass-through, 0-cycle latency).
  - io_resp_yumi_o = io_resp_v_i & ~empty & io_resp_ready_i[head].
  - On io_resp_yumi_o: pop the FIFO and decrement the count.
- Simultaneous issue and retire in one cycle: push and pop both occur and the count is unchanged. Legal whenever not full.
- Empty FIFO with io_resp_v_i=1 (protocol violation): io_resp_yumi_o=0 and the response is held upstream. See the optional feature.
- Latency:
  - Command path: 0 cycles (combinational).
  - Response path: 0 cycles.
  - Single-cycle issue and retire back-to-back.
- Widths: count is $clog2(max_outstanding_p+1) bits; FIFO pointers are $clog2(max_outstanding_p) bits with wrap-around.

Optional Feature:
- Macro BP_IO_ARB_ERR_EN.
- When defined:
  - Adds output port err_o (1 bit, reset 0).
  - err_o is sticky and is set on the first cycle where io_resp_v_i=1 and the FIFO is empty.
  - In that case io_resp_yumi_o=1 and the stray response is dropped, so the link does not deadlock.
  - Only reset_i clears err_o.
- When undefined:
  - No err_o port.
  - A stray response is held (yumi=0) indefinitely.

Test Plan:
- Reset, then io_cmd_v_i=2'b11 with io_cmd_yumi_i held at 1 for 4 cycles → grants 0,1,0,1. FIFO holds [0,1,0,1], full=1, io_cmd_v_o=0 in cycle 5.
- Then 4 responses A,B,C,D with ready=2'b11 → io_resp_v_o = 01,10,01,10 carrying A..D, count returns to 0, issue resumes.
- Only requester 1 valid for 3 commands with yumi every cycle → grants 1,1,1 with no bubbles; rr_ptr=0 afterwards.
- Full (count=4) while a response retires in the same cycle with io_cmd_v_i=1 → no issue that cycle, issue next cycle, count goes 4→3→4.
- Head=0 with io_resp_ready_i[0]=0 for 3 cycles → io_resp_yumi_o=0 and io_resp_v_o=01 held. Ready rises → single pop.
- Assert reset_i asynchronously with 2 commands outstanding → outputs 0 immediately. After release: count=0, rr_ptr=0.
- A response with an empty FIFO:
  - Without BP_IO_ARB_ERR_EN: held, yumi=0.
  - With BP_IO_ARB_ERR_EN: dropped, err_o=1 until reset.
